// File: rtl/rf_writeback_unit.sv
// Register-file write-port arbiter: merges ALU results and queued/bypassed MDU results,
// and keeps a busy scoreboard of in-flight MDU destinations for decode-stage hazard stalls.
module rf_writeback_unit #(
    parameter int XLEN           = 32,
    parameter int MDU_FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_wb_en,
    input  logic [4:0]                        alu_wb_rd,
    input  logic [XLEN-1:0]                   alu_wb_data,
    input  logic                              mdu_wb_valid,
    output logic                              mdu_wb_ready,
    input  logic [4:0]                        mdu_wb_rd,
    input  logic [XLEN-1:0]                   mdu_wb_data,
    input  logic                              issue_mdu_en,
    input  logic [4:0]                        issue_rd,
    input  logic                              chk_rs1_en,
    input  logic [4:0]                        chk_rs1_address,
    input  logic                              chk_rs2_en,
    input  logic [4:0]                        chk_rs2_address,
    input  logic                              chk_rd_en,
    input  logic [4:0]                        chk_rd_address,
    output logic                              stall_reg_rd,
    output logic                              wr_rd_en,
    output logic [4:0]                        rd_adress,
    output logic [XLEN-1:0]                   rd_data,
    output logic [$clog2(MDU_FIFO_DEPTH):0]   mdu_fifo_count
);

    localparam int PW = $clog2(MDU_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fifo_data_q [MDU_FIFO_DEPTH];
    logic [4:0]      fifo_rd_q   [MDU_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     busy_q, busy_d;

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic            fifo_empty, fifo_full;
    logic            deq, bypass, enq;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            mdu_loaded;
    logic [4:0]      mdu_loaded_rd;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(MDU_FIFO_DEPTH));

    // ALU has absolute priority; the queue head beats a fresh MDU result so order is kept.
    assign deq          = !alu_wb_en && !fifo_empty;
    assign bypass       = !alu_wb_en && fifo_empty && mdu_wb_valid;
    assign mdu_wb_ready = !fifo_full || deq;
    assign enq          = mdu_wb_valid && mdu_wb_ready && !bypass;

    always_comb begin
        sel_valid     = 1'b0;
        sel_rd        = 5'd0;
        sel_data      = '0;
        mdu_loaded    = 1'b0;
        mdu_loaded_rd = 5'd0;
        if (alu_wb_en) begin
            sel_valid = 1'b1;
            sel_rd    = alu_wb_rd;
            sel_data  = alu_wb_data;
        end else if (deq) begin
            sel_valid     = 1'b1;
            sel_rd        = fifo_rd_q[rd_ptr_q];
            sel_data      = fifo_data_q[rd_ptr_q];
            mdu_loaded    = 1'b1;
            mdu_loaded_rd = fifo_rd_q[rd_ptr_q];
        end else if (bypass) begin
            sel_valid     = 1'b1;
            sel_rd        = mdu_wb_rd;
            sel_data      = mdu_wb_data;
            mdu_loaded    = 1'b1;
            mdu_loaded_rd = mdu_wb_rd;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = 5'd0;
        wr_data_d = '0;
        if (sel_valid && (sel_rd != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_rd;
            wr_data_d = sel_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set is applied after clear so a same-cycle reissue to the same rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (mdu_loaded) busy_d[mdu_loaded_rd] = 1'b0;
        if (issue_mdu_en) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data_q[wr_ptr_q] <= mdu_wb_data;
            fifo_rd_q[wr_ptr_q]   <= mdu_wb_rd;
        end
    end

    assign stall_reg_rd = (chk_rs1_en && busy_q[chk_rs1_address])
                        | (chk_rs2_en && busy_q[chk_rs2_address])
                        | (chk_rd_en  && busy_q[chk_rd_address])
                        | (issue_mdu_en && fifo_full);

    assign wr_rd_en       = wr_en_q;
    assign rd_adress      = wr_addr_q;
    assign rd_data        = wr_data_q;
    assign mdu_fifo_count = count_q;

endmodule

// File: doc/rf_writeback_unit.md
Name: rf_writeback_unit

Overview:
- Writer-side counterpart to the register file.
- Merges single-cycle ALU results and multi-cycle MUL/DIV (MDU) results into the single register-file write port (wr_rd_en / rd_adress / rd_data).
- Holds a busy-register scoreboard for in-flight MDU destinations and drives stall_reg_rd to the register-file read stage.
- Sits between the execute stage and the register file.

Parameters:
- XLEN, 32, data width of results and write port.
- MDU_FIFO_DEPTH, 2, MDU result queue entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_wb_en  input  1  ALU result valid this cycle; no backpressure.
- alu_wb_rd  input  5  ALU destination register.
- alu_wb_data  input  XLEN  ALU result.
- mdu_wb_valid  input  1  MDU result offered.
- mdu_wb_ready  output  1  MDU result accepted when valid and ready are both high.
- mdu_wb_rd  input  5  MDU destination register.
- mdu_wb_data  input  XLEN  MDU result.
- issue_mdu_en  input  1  MDU op issued this cycle; marks its destination busy.
- issue_rd  input  5  destination of the issued MDU op.
- chk_rs1_en  input  1  decode stage reads rs1.
- chk_rs1_address  input  5  rs1 index to check.
- chk_rs2_en  input  1  decode stage reads rs2.
- chk_rs2_address  input  5  rs2 index to check.
- chk_rd_en  input  1  decode stage writes rd (WAW check).
- chk_rd_address  input  5  rd index to check.
- stall_reg_rd  output  1  hazard stall to the register-file read stage.
- wr_rd_en  output  1  register-file write enable.
- rd_adress  output  5  register-file write address.
- rd_data  output  XLEN  register-file write data.
- mdu_fifo_count  output  $clog2(MDU_FIFO_DEPTH)+1  current MDU queue occupancy.

Behaviour:
- Reset (reset low, asynchronous): wr_rd_en=0, rd_adress=0, rd_data=0, FIFO emptied (mdu_fifo_count=0), all busy bits cleared. Applies mid-operation; queued MDU results are discarded.
- While reset is asserted, mdu_wb_ready=1 and stall_reg_rd reflects the empty scoreboard (0).
- Write port outputs are registered. A result presented in cycle N appears on wr_rd_en/rd_adress/rd_data in cycle N+1 and lasts exactly one cycle.
- At most one register write per cycle. Select order each cycle:
  - (a) alu_wb_en.
  - (b) else the FIFO head.
  - (c) else the MDU bypass: FIFO empty and mdu_wb_valid; the result goes straight to the output registers and is not enqueued.
- MDU results not bypassed are enqueued on handshake.
- mdu_wb_ready = FIFO not full, or FIFO holds exactly DEPTH entries and the head dequeues this cycle. Enqueue and dequeue in the same cycle are legal; occupancy is unchanged.
- FIFO pointers wrap modulo MDU_FIFO_DEPTH. Order is strictly FIFO.
- Destination x0: the write is suppressed (wr_rd_en=0, rd_adress=0, rd_data=0). It still dequeues or consumes normally.
- Scoreboard: busy[1..31], busy[0] hardwired 0.
  - Set on issue_mdu_en with issue_rd != 0.
  - Cleared on the same edge that loads an MDU result for that rd into the write-port registers. The register file forwards during that cycle, so a read released one cycle later sees the correct value.
  - Simultaneous set and clear of the same index: set wins.
- ALU results never touch the scoreboard.
- stall_reg_rd (combinational from busy state and chk inputs) = (chk_rs1_en & busy[rs1]) | (chk_rs2_en & busy[rs2]) | (chk_rd_en & busy[rd]) | (issue_mdu_en & FIFO full).
- Index 0 never stalls.
- Protocol violations, with undefined results and no recovery required:
  - Issuing an MDU op to an already-busy rd.
  - An ALU write to a busy rd.
  - The WAW check exists to prevent both.

Test Plan:
- Reset with FIFO at 2 and busy[5]=1 -> next cycle wr_rd_en=0, mdu_fifo_count=0, busy cleared, mdu_wb_ready=1, stall_reg_rd=0 with chk_rs1=5.
- alu_wb_en=1, rd=3, data=0x0000_00AA in cycle N -> cycle N+1: wr_rd_en=1, rd_adress=3, rd_data=0xAA. Cycle N+2: wr_rd_en=0.
- Issue MDU rd=7, then check rs1=7 -> stall_reg_rd=1 until the MDU result (0x1234_5678) is written via bypass. Stall drops in the cycle wr_rd_en=1 with rd_adress=7.
- ALU writes in 4 consecutive cycles while the MDU offers 3 results -> 2 accepted, mdu_wb_ready=0 on the third until the ALU idles. Queued results drain in order one per cycle after the ALU stops.
- MDU result rd=0, data=0xFFFF_FFFF -> handshake completes, wr_rd_en stays 0, mdu_fifo_count unchanged.
- Issue to rd=9 in the same cycle the previous rd=9 MDU result clears -> busy[9] remains 1 and the stall persists on check rs2=9.
